// File: rtl/srfpu_pkg.sv
// Shared types and constants for the SRFPU memory arbiter slice.
package srfpu_pkg;

    localparam int unsigned MEM_AW = 32;
    localparam int unsigned MEM_DW = 32;
    localparam int unsigned MEM_SW = MEM_DW / 8;

    // Encodings are visible on grant_state: IDLE=0, CPU=1, FPU=2.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_FPU  = 2'd2
    } arb_state_t;

    // Watchdog counter width: enough to hold TIMEOUT_CYCLES, never below 1 bit.
    function automatic int unsigned wdog_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/srfpu_rr_pick2.sv
// Combinational two-way pick. Bit 1 is the FPU, bit 0 is the CPU.
// 'last' = 1 means the FPU was served most recently; 'fixed' makes the FPU win ties.
module srfpu_rr_pick2
    import srfpu_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed,
    output logic [1:0] gnt
);

    // One-hot grant; on a tie the master not served last wins unless fixed priority.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (fixed || !last) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/srfpu_mem_arbiter.sv
// Shares one native memory port between the PicoRV32 core and the SRFPU
// load/store path. Each grant is held until mem_ready or a watchdog abort.
module srfpu_mem_arbiter
    import srfpu_pkg::*;
#(
    parameter bit                FPU_PRIORITY   = 1'b0,
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter logic [MEM_DW-1:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              cpu_mem_valid,
    input  logic [MEM_AW-1:0] cpu_mem_addr,
    input  logic [MEM_DW-1:0] cpu_mem_wdata,
    input  logic [MEM_SW-1:0] cpu_mem_wstrb,
    output logic              cpu_mem_ready,
    output logic [MEM_DW-1:0] cpu_mem_rdata,

    input  logic              fpu_mem_valid,
    input  logic [MEM_AW-1:0] fpu_mem_addr,
    input  logic [MEM_DW-1:0] fpu_mem_wdata,
    input  logic [MEM_SW-1:0] fpu_mem_wstrb,
    output logic              fpu_mem_ready,
    output logic [MEM_DW-1:0] fpu_mem_rdata,

    output logic              mem_valid,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wdata,
    output logic [MEM_SW-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic [MEM_DW-1:0] mem_rdata,

    output logic [1:0]        grant_state,
    output logic              timeout_err
);

    localparam int unsigned    WD_W    = wdog_width(TIMEOUT_CYCLES);
    localparam bit             WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_mem_valid;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [MEM_DW-1:0] r_mem_wdata;
    logic [MEM_SW-1:0] r_mem_wstrb;
    logic              r_last_fpu;
    logic [WD_W-1:0]   r_wdog;
    logic              r_timeout_err;

    logic [1:0]        w_gnt;
    logic              w_busy;
    logic              w_timeout;
    logic              w_finish;
    logic [MEM_DW-1:0] w_resp_rdata;

    srfpu_rr_pick2 u_pick (
        .req   ({fpu_mem_valid, cpu_mem_valid}),
        .last  (r_last_fpu),
        .fixed (FPU_PRIORITY),
        .gnt   (w_gnt)
    );

    assign w_busy    = (r_state == ARB_CPU) || (r_state == ARB_FPU);
    // A same-cycle mem_ready takes precedence over the watchdog abort.
    assign w_timeout = WD_EN && w_busy && !mem_ready && (r_wdog == WD_LAST);
    assign w_finish  = w_busy && (mem_ready || w_timeout);
    assign w_resp_rdata = w_timeout ? ERR_RDATA : mem_rdata;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: arbitrate in IDLE, return to IDLE when a transfer finishes.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_gnt[1]) begin
                    w_next_state = ARB_FPU;
                end else if (w_gnt[0]) begin
                    w_next_state = ARB_CPU;
                end
            end
            ARB_CPU, ARB_FPU: begin
                if (w_finish) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    // Shared-port request registers, fairness bit, watchdog and sticky error.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_valid   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_wstrb   <= '0;
            r_last_fpu    <= 1'b0;
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_wdog <= '0;
                    if (w_gnt[1]) begin
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= fpu_mem_addr;
                        r_mem_wdata <= fpu_mem_wdata;
                        r_mem_wstrb <= fpu_mem_wstrb;
                    end else if (w_gnt[0]) begin
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= cpu_mem_addr;
                        r_mem_wdata <= cpu_mem_wdata;
                        r_mem_wstrb <= cpu_mem_wstrb;
                    end
                end
                ARB_CPU, ARB_FPU: begin
                    if (w_finish) begin
                        r_mem_valid <= 1'b0;
                        r_last_fpu  <= (r_state == ARB_FPU);
                        r_wdog      <= '0;
                    end else if (WD_EN) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                    if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                    end
                end
                default: r_mem_valid <= 1'b0;
            endcase
        end
    end

    // Route completion to the granted master only; the other side sees zeros.
    always_comb begin
        cpu_mem_ready = 1'b0;
        cpu_mem_rdata = '0;
        fpu_mem_ready = 1'b0;
        fpu_mem_rdata = '0;
        if (r_state == ARB_CPU) begin
            cpu_mem_ready = mem_ready || w_timeout;
            cpu_mem_rdata = w_resp_rdata;
        end else if (r_state == ARB_FPU) begin
            fpu_mem_ready = mem_ready || w_timeout;
            fpu_mem_rdata = w_resp_rdata;
        end
    end

    assign mem_valid   = r_mem_valid;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_wstrb   = r_mem_wstrb;
    assign grant_state = r_state;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_srfpu_mem_arbiter.sv
// Directed scoreboard bench for srfpu_mem_arbiter. A second instance with
// fixed FPU priority shares the stimulus to exercise the tie-break option.
module tb_srfpu_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        cpu_mem_valid, fpu_mem_valid;
    logic [31:0] cpu_mem_addr, cpu_mem_wdata, fpu_mem_addr, fpu_mem_wdata;
    logic [3:0]  cpu_mem_wstrb, fpu_mem_wstrb;
    logic        cpu_mem_ready, fpu_mem_ready;
    logic [31:0] cpu_mem_rdata, fpu_mem_rdata;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  grant_state;
    logic        timeout_err;

    logic        p_cpu_mem_ready, p_fpu_mem_ready, p_mem_valid, p_timeout_err;
    logic [31:0] p_cpu_mem_rdata, p_fpu_mem_rdata, p_mem_addr, p_mem_wdata;
    logic [3:0]  p_mem_wstrb;
    logic [1:0]  p_grant_state;

    typedef struct packed {
        logic        fpu;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    srfpu_mem_arbiter #(
        .FPU_PRIORITY   (1'b0),
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .resetn(resetn),
        .cpu_mem_valid(cpu_mem_valid), .cpu_mem_addr(cpu_mem_addr),
        .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_wstrb(cpu_mem_wstrb),
        .cpu_mem_ready(cpu_mem_ready), .cpu_mem_rdata(cpu_mem_rdata),
        .fpu_mem_valid(fpu_mem_valid), .fpu_mem_addr(fpu_mem_addr),
        .fpu_mem_wdata(fpu_mem_wdata), .fpu_mem_wstrb(fpu_mem_wstrb),
        .fpu_mem_ready(fpu_mem_ready), .fpu_mem_rdata(fpu_mem_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant_state(grant_state), .timeout_err(timeout_err)
    );

    srfpu_mem_arbiter #(
        .FPU_PRIORITY   (1'b1),
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (32'hDEAD_BEEF)
    ) dut_fixed (
        .clk(clk), .resetn(resetn),
        .cpu_mem_valid(cpu_mem_valid), .cpu_mem_addr(cpu_mem_addr),
        .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_wstrb(cpu_mem_wstrb),
        .cpu_mem_ready(p_cpu_mem_ready), .cpu_mem_rdata(p_cpu_mem_rdata),
        .fpu_mem_valid(fpu_mem_valid), .fpu_mem_addr(fpu_mem_addr),
        .fpu_mem_wdata(fpu_mem_wdata), .fpu_mem_wstrb(fpu_mem_wstrb),
        .fpu_mem_ready(p_fpu_mem_ready), .fpu_mem_rdata(p_fpu_mem_rdata),
        .mem_valid(p_mem_valid), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
        .mem_wstrb(p_mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant_state(p_grant_state), .timeout_err(p_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req_cpu(input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input logic [31:0] rd);
        exp_t e;
        cpu_mem_valid = 1'b1; cpu_mem_addr = a; cpu_mem_wdata = wd; cpu_mem_wstrb = ws;
        e.fpu = 1'b0; e.addr = a; e.wdata = wd; e.wstrb = ws; e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic req_fpu(input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input logic [31:0] rd);
        exp_t e;
        fpu_mem_valid = 1'b1; fpu_mem_addr = a; fpu_mem_wdata = wd; fpu_mem_wstrb = ws;
        e.fpu = 1'b1; e.addr = a; e.wdata = wd; e.wstrb = ws; e.rdata = rd;
        sb.push_back(e);
    endtask

    // Wait for the issue, hold mem_ready off for 'lat' cycles, then complete.
    // mode 0: the served master drops valid; mode 1: it re-requests at addr+4.
    task automatic serve(input int unsigned exp_wait, input int unsigned lat,
                         input int mode, input int g2);
        exp_t e;
        int unsigned n;
        n = 0;
        while (!mem_valid && n < 20) begin
            step();
            n++;
        end
        chk("issue_latency", n, exp_wait);
        chk("sb_depth_nonzero", 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb[0];
        chk("grant", 32'(grant_state), e.fpu ? 32'd2 : 32'd1);
        if (g2 >= 0) chk("grant_fixed", 32'(p_grant_state), 32'(g2));
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_wdata", mem_wdata, e.wdata);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
        for (int unsigned k = 0; k < lat; k++) begin
            chk("no_early_ready", 32'({cpu_mem_ready, fpu_mem_ready}), 32'd0);
            step();
            chk("frozen_addr", mem_addr, e.addr);
            chk("frozen_wdata", mem_wdata, e.wdata);
            chk("frozen_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
        end
        mem_ready = 1'b1;
        mem_rdata = e.rdata;
        #1;
        e = sb.pop_front();
        chk("ready_granted", 32'(e.fpu ? fpu_mem_ready : cpu_mem_ready), 32'd1);
        chk("rdata_granted", e.fpu ? fpu_mem_rdata : cpu_mem_rdata, e.rdata);
        chk("ready_other", 32'(e.fpu ? cpu_mem_ready : fpu_mem_ready), 32'd0);
        chk("rdata_other", e.fpu ? cpu_mem_rdata : fpu_mem_rdata, 32'd0);
        if (e.fpu) begin
            if (mode == 1) req_fpu(e.addr + 32'd4, e.wdata, e.wstrb, e.rdata + 32'd1);
            else fpu_mem_valid = 1'b0;
        end else begin
            if (mode == 1) req_cpu(e.addr + 32'd4, e.wdata, e.wstrb, e.rdata + 32'd1);
            else cpu_mem_valid = 1'b0;
        end
        step();
        mem_ready = 1'b0;
        mem_rdata = '0;
        chk("bubble_valid", 32'(mem_valid), 32'd0);
        chk("bubble_state", 32'(grant_state), 32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        int unsigned n;
        exp_t e;
        resetn = 1'b0;
        cpu_mem_valid = 1'b0; cpu_mem_addr = '0; cpu_mem_wdata = '0; cpu_mem_wstrb = '0;
        fpu_mem_valid = 1'b0; fpu_mem_addr = '0; fpu_mem_wdata = '0; fpu_mem_wstrb = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        step();
        step();

        // Reset state of both instances.
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_state", 32'(grant_state), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_readies", 32'({cpu_mem_ready, fpu_mem_ready}), 32'd0);
        chk("rst_rdata", cpu_mem_rdata | fpu_mem_rdata, 32'd0);
        chk("rst_p_mem_valid", 32'(p_mem_valid), 32'd0);
        chk("rst_p_mem_addr", p_mem_addr, 32'd0);
        chk("rst_p_mem_wdata", p_mem_wdata, 32'd0);
        chk("rst_p_mem_wstrb", 32'(p_mem_wstrb), 32'd0);
        chk("rst_p_state", 32'(p_grant_state), 32'd0);
        chk("rst_p_timeout_err", 32'(p_timeout_err), 32'd0);
        chk("rst_p_readies", 32'({p_cpu_mem_ready, p_fpu_mem_ready}), 32'd0);
        chk("rst_p_rdata", p_cpu_mem_rdata | p_fpu_mem_rdata, 32'd0);
        resetn = 1'b1;

        // 1: single CPU read, memory answers one cycle after mem_valid.
        req_cpu(32'h0000_0100, 32'h0, 4'h0, 32'h1234_5678);
        serve(1, 1, 0, 1);

        // 2: simultaneous requests from reset, FPU first then CPU.
        do_reset();
        req_fpu(32'h0000_0300, 32'h0, 4'h0, 32'hF0F0_0001);
        req_cpu(32'h0000_0200, 32'h0, 4'h0, 32'hC0C0_0001);
        serve(1, 0, 0, 2);
        serve(1, 0, 0, 1);

        // 3: continuous re-requests alternate F,C,F,C,F,C; fixed priority stays on FPU.
        req_fpu(32'h0000_1000, 32'h0, 4'h0, 32'hF000_0000);
        req_cpu(32'h0000_2000, 32'h0, 4'h0, 32'hC000_0000);
        serve(1, 0, 1, 2);
        serve(1, 0, 1, 2);
        serve(1, 1, 1, 2);
        serve(1, 0, 1, 2);
        serve(1, 2, 0, 2);
        serve(1, 0, 0, 1);

        // 4: FPU write holds the shared port while CPU inputs change underneath.
        req_fpu(32'h0000_0400, 32'hAABB_CCDD, 4'b0011, 32'h0);
        step();
        req_cpu(32'hCAFE_0000, 32'h5555_5555, 4'b1111, 32'h0BAD_F00D);
        serve(0, 4, 0, -1);
        serve(1, 1, 0, -1);

        // 5a: mem_ready on the final watchdog cycle completes normally.
        req_fpu(32'h0000_0600, 32'h0, 4'h0, 32'h600D_600D);
        serve(1, 7, 0, -1);
        chk("no_tmo_on_last_cycle", 32'(timeout_err), 32'd0);

        // 5b: memory never answers; abort after 8 busy cycles with ERR_RDATA.
        req_cpu(32'h0000_0500, 32'h0, 4'h0, 32'hDEAD_BEEF);
        n = 0;
        while (!mem_valid && n < 20) begin
            step();
            n++;
        end
        chk("tmo_issue_latency", n, 32'd1);
        for (int unsigned k = 0; k < 7; k++) begin
            chk("tmo_no_early_ready", 32'(cpu_mem_ready), 32'd0);
            step();
        end
        e = sb.pop_front();
        chk("tmo_ready", 32'(cpu_mem_ready), 32'd1);
        chk("tmo_rdata", cpu_mem_rdata, e.rdata);
        chk("tmo_fpu_ready", 32'(fpu_mem_ready), 32'd0);
        cpu_mem_valid = 1'b0;
        step();
        chk("tmo_err_set", 32'(timeout_err), 32'd1);
        chk("tmo_valid_drop", 32'(mem_valid), 32'd0);
        chk("tmo_state", 32'(grant_state), 32'd0);

        // Late mem_ready while idle is ignored.
        mem_ready = 1'b1;
        mem_rdata = 32'h7777_7777;
        #1;
        chk("late_ready_ignored", 32'({cpu_mem_ready, fpu_mem_ready}), 32'd0);
        step();
        mem_ready = 1'b0;
        mem_rdata = '0;
        chk("late_ready_state", 32'(grant_state), 32'd0);
        chk("late_ready_valid", 32'(mem_valid), 32'd0);

        // Error flag stays set across a later normal transfer.
        req_cpu(32'h0000_0504, 32'h0, 4'h0, 32'h1111_2222);
        serve(1, 0, 0, -1);
        chk("tmo_err_sticky", 32'(timeout_err), 32'd1);

        // 6: reset asserted mid FPU transfer, then a pending CPU request.
        fpu_mem_valid = 1'b1; fpu_mem_addr = 32'h0000_0700;
        fpu_mem_wdata = 32'h0; fpu_mem_wstrb = 4'h0;
        step();
        chk("pre_rst_state", 32'(grant_state), 32'd2);
        chk("pre_rst_valid", 32'(mem_valid), 32'd1);
        req_cpu(32'h0000_0800, 32'h0, 4'h0, 32'h8888_0001);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_valid", 32'(mem_valid), 32'd0);
        chk("midrst_state", 32'(grant_state), 32'd0);
        chk("midrst_readies", 32'({cpu_mem_ready, fpu_mem_ready}), 32'd0);
        chk("midrst_tmo_err", 32'(timeout_err), 32'd0);
        fpu_mem_valid = 1'b0;
        step();
        chk("in_rst_valid", 32'(mem_valid), 32'd0);
        resetn = 1'b1;
        serve(1, 1, 0, -1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
